// File: rtl/fetch_mem_ctrl_pkg.sv
// Shared types and constants for the fetch-stage instruction-memory controller.
// A 64-bit memory block holds INSTS_PER_BLOCK 32-bit instructions.
package fetch_mem_ctrl_pkg;

   localparam int unsigned INSTS_PER_BLOCK = 2;
   localparam int unsigned N               = INSTS_PER_BLOCK;
   localparam int unsigned NUM_SCALAR_BITS = 3;
   localparam int unsigned WORD_IDX_BITS   = $clog2(INSTS_PER_BLOCK);
   localparam int unsigned MEM_TAG_BITS    = 4;

   typedef logic [31:0]             ADDR;
   typedef logic [31:0]             INST;
   typedef logic [63:0]             MEM_BLOCK;
   typedef logic [MEM_TAG_BITS-1:0] MEM_TAG;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'h0,
      MEM_LOAD  = 2'h1,
      MEM_STORE = 2'h2
   } MEM_COMMAND;

   typedef struct packed {
      INST inst;
      ADDR PC;
   } FETCH_PACKET;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDeliver
   } fetch_state_e;

   // Instructions left in the block from the given word offset onwards.
   function automatic logic [NUM_SCALAR_BITS-1:0] deliver_count(
      input logic [WORD_IDX_BITS-1:0] offset
   );
      return NUM_SCALAR_BITS'(INSTS_PER_BLOCK) - NUM_SCALAR_BITS'(offset);
   endfunction

endpackage

// File: rtl/fetch_mem_ctrl_if.sv
// Instruction-memory bus between the fetch controller (master) and memory (slave).
interface fetch_mem_ctrl_if;
   import fetch_mem_ctrl_pkg::*;

   MEM_COMMAND Imem_command;
   ADDR        Imem_addr;
   MEM_TAG     Imem2proc_transaction_tag;
   MEM_TAG     Imem2proc_data_tag;
   MEM_BLOCK   Imem2proc_data;

   modport master (
      output Imem_command,
      output Imem_addr,
      input  Imem2proc_transaction_tag,
      input  Imem2proc_data_tag,
      input  Imem2proc_data
   );

   modport slave (
      input  Imem_command,
      input  Imem_addr,
      output Imem2proc_transaction_tag,
      output Imem2proc_data_tag,
      output Imem2proc_data
   );

endinterface

// File: rtl/fetch_block_split.sv
// Splits a memory block into fetch packets starting at a word offset.
// Packets at or beyond cnt are zero.
module fetch_block_split
   import fetch_mem_ctrl_pkg::*;
(
   input  MEM_BLOCK                   block,
   input  ADDR                        base_PC,
   input  logic [WORD_IDX_BITS-1:0]   offset,
   input  logic [NUM_SCALAR_BITS-1:0] cnt,
   output FETCH_PACKET [N-1:0]        packets
);

   INST [INSTS_PER_BLOCK-1:0] words;
   assign words = block;

   always_comb begin
      packets = '0;
      for (int i = 0; i < N; i++) begin
         if (NUM_SCALAR_BITS'(i) < cnt) begin
            packets[i].inst = words[offset + WORD_IDX_BITS'(i)];
            packets[i].PC   = base_PC + ADDR'(4 * i);
         end
      end
   end

endmodule

// File: rtl/fetch_mem_ctrl.sv
// Fetch-stage instruction-memory sequencer: one block load at a time, tag-matched
// response, all-or-nothing delivery. Optional counters under FETCH_PERF_CNT_EN.
module fetch_mem_ctrl
   import fetch_mem_ctrl_pkg::*;
#(
   parameter ADDR RESET_PC = 32'h0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       redirect_valid,
   input  ADDR                        redirect_PC,
   fetch_mem_ctrl_if.master           imem,
   input  logic [NUM_SCALAR_BITS-1:0] inst_buffer_spots,
   output FETCH_PACKET [N-1:0]        inst_buffer_inputs,
   output logic [NUM_SCALAR_BITS-1:0] instructions_valid,
   output logic                       fetch_busy
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                perf_stall_cycles,
   output logic [31:0]                perf_squashed_reqs
`endif
);

   fetch_state_e state;
   ADDR          fetch_PC;
   MEM_TAG       saved_tag;
   MEM_BLOCK     block_reg;

   logic [WORD_IDX_BITS-1:0]   offset;
   logic [NUM_SCALAR_BITS-1:0] cnt;
   logic                       accepted;
   logic                       data_hit;
   logic                       deliver_fire;

   assign offset       = fetch_PC[2 +: WORD_IDX_BITS];
   assign cnt          = deliver_count(offset);
   assign accepted     = imem.Imem2proc_transaction_tag != '0;
   // Tag 0 means "nothing returned", so it can never match.
   assign data_hit     = (imem.Imem2proc_data_tag == saved_tag) && (imem.Imem2proc_data_tag != '0);
   assign deliver_fire = (state == StDeliver) && !reset && !redirect_valid &&
                         (inst_buffer_spots >= cnt);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= StIdle;
         fetch_PC  <= RESET_PC;
         saved_tag <= '0;
         block_reg <= '0;
      end else if (redirect_valid) begin
         // Clearing saved_tag orphans any outstanding or same-cycle-accepted tag.
         fetch_PC  <= redirect_PC & ~ADDR'(3);
         saved_tag <= '0;
         state     <= StReq;
      end else begin
         unique case (state)
            StIdle: state <= StReq;
            StReq: begin
               if (accepted) begin
                  saved_tag <= imem.Imem2proc_transaction_tag;
                  state     <= StWait;
               end
            end
            StWait: begin
               if (data_hit) begin
                  block_reg <= imem.Imem2proc_data;
                  state     <= StDeliver;
               end
            end
            StDeliver: begin
               if (deliver_fire) begin
                  fetch_PC <= {fetch_PC[31:3] + 29'd1, 3'b000};
                  state    <= StReq;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign imem.Imem_command = (state == StReq && !reset) ? MEM_LOAD : MEM_NONE;
   assign imem.Imem_addr    = (state == StReq && !reset) ? {fetch_PC[31:3], 3'b000} : '0;
   assign fetch_busy        = !reset && (state == StReq || state == StWait);
   assign instructions_valid = deliver_fire ? cnt : '0;

   fetch_block_split u_split (
      .block   (block_reg),
      .base_PC (fetch_PC),
      .offset  (offset),
      .cnt     (instructions_valid),
      .packets (inst_buffer_inputs)
   );

`ifdef FETCH_PERF_CNT_EN
   logic stall_evt;
   logic squash_evt;

   assign stall_evt  = (state == StDeliver) && (inst_buffer_spots < cnt);
   assign squash_evt = redirect_valid && (state == StWait || (state == StReq && accepted));

   always_ff @(posedge clock) begin
      if (reset) begin
         perf_stall_cycles  <= '0;
         perf_squashed_reqs <= '0;
      end else begin
         if (stall_evt && perf_stall_cycles != '1) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
         if (squash_evt && perf_squashed_reqs != '1) begin
            perf_squashed_reqs <= perf_squashed_reqs + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// Bench for fetch_mem_ctrl: directed vector table, hand-written squash/reset
// sequences, then random traffic against a behavioural model.
module tb_fetch_mem_ctrl;
   import fetch_mem_ctrl_pkg::*;

   logic                       clock = 1'b0;
   logic                       reset = 1'b1;
   logic                       redirect_valid = 1'b0;
   ADDR                        redirect_PC = '0;
   logic [NUM_SCALAR_BITS-1:0] inst_buffer_spots = '0;
   FETCH_PACKET [N-1:0]        inst_buffer_inputs;
   logic [NUM_SCALAR_BITS-1:0] instructions_valid;
   logic                       fetch_busy;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]                perf_stall_cycles;
   logic [31:0]                perf_squashed_reqs;
`endif

   fetch_mem_ctrl_if imem ();

   fetch_mem_ctrl #(.RESET_PC(32'h0)) dut (
      .clock              (clock),
      .reset              (reset),
      .redirect_valid     (redirect_valid),
      .redirect_PC        (redirect_PC),
      .imem               (imem),
      .inst_buffer_spots  (inst_buffer_spots),
      .inst_buffer_inputs (inst_buffer_inputs),
      .instructions_valid (instructions_valid),
      .fetch_busy         (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_stall_cycles  (perf_stall_cycles),
      .perf_squashed_reqs (perf_squashed_reqs)
`endif
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       rv;
      ADDR        rpc;
      MEM_TAG     tt;
      MEM_TAG     dt;
      MEM_BLOCK   d;
      logic [2:0] sp;
      MEM_COMMAND cmd;
      ADDR        addr;
      logic       busy;
      logic [2:0] vld;
      logic [127:0] pk;
   } vec_t;

   vec_t tbl[$];

   // Behavioural model: what is outstanding, expressed as simple flags.
   ADDR      m_pc;
   bit       m_req;
   bit       m_full;
   MEM_TAG   m_tag;
   MEM_BLOCK m_blk;

   function automatic vec_t mk(input logic rv, input ADDR rpc, input MEM_TAG tt,
                               input MEM_TAG dt, input MEM_BLOCK d, input logic [2:0] sp,
                               input MEM_COMMAND cmd, input ADDR addr, input logic busy,
                               input logic [2:0] vld, input logic [127:0] pk);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.tt = tt; v.dt = dt; v.d = d; v.sp = sp;
      v.cmd = cmd; v.addr = addr; v.busy = busy; v.vld = vld; v.pk = pk;
      return v;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic rst, input logic rv, input ADDR rpc, input MEM_TAG tt,
                        input MEM_TAG dt, input MEM_BLOCK d, input logic [2:0] sp);
      @(negedge clock);
      reset                          = rst;
      redirect_valid                 = rv;
      redirect_PC                    = rpc;
      imem.Imem2proc_transaction_tag = tt;
      imem.Imem2proc_data_tag        = dt;
      imem.Imem2proc_data            = d;
      inst_buffer_spots              = sp;
      #2;
   endtask

   task automatic expect_out(input string nm, input MEM_COMMAND cmd, input ADDR addr,
                             input logic busy, input logic [2:0] vld, input logic [127:0] pk);
      check({nm, ".cmd"},  128'(imem.Imem_command), 128'(cmd));
      check({nm, ".addr"}, 128'(imem.Imem_addr),    128'(addr));
      check({nm, ".busy"}, 128'(fetch_busy),        128'(busy));
      check({nm, ".vld"},  128'(instructions_valid), 128'(vld));
      check({nm, ".pkt"},  128'(inst_buffer_inputs), pk);
   endtask

   task automatic hand(input string nm, input logic rst, input logic rv, input ADDR rpc,
                       input MEM_TAG tt, input MEM_TAG dt, input MEM_BLOCK d,
                       input logic [2:0] sp, input MEM_COMMAND cmd, input ADDR addr,
                       input logic busy, input logic [2:0] vld, input logic [127:0] pk);
      apply(rst, rv, rpc, tt, dt, d, sp);
      expect_out(nm, cmd, addr, busy, vld, pk);
   endtask

   function automatic void model_reset();
      m_pc = 32'h0; m_req = 0; m_full = 0; m_tag = '0; m_blk = '0;
   endfunction

   task automatic model_cycle(input logic rst, input logic rv, input ADDR rpc, input MEM_TAG tt,
                              input MEM_TAG dt, input MEM_BLOCK d, input logic [2:0] sp);
      int unsigned off, n;
      logic [2:0]  vld;
      logic [127:0] pk;
      apply(rst, rv, rpc, tt, dt, d, sp);
      if (rst) begin
         expect_out("rnd_reset", MEM_NONE, 32'h0, 1'b0, 3'd0, '0);
         model_reset();
      end else begin
         off = (m_pc % 8) / 4;
         n   = 2 - off;
         vld = (m_full && !rv && sp >= 3'(n)) ? 3'(n) : 3'd0;
         pk  = '0;
         for (int i = 0; i < int'(vld); i++) begin
            pk[64*i +: 64] = {32'(m_blk >> (32 * (off + i))), m_pc + 32'(4 * i)};
         end
         expect_out("rnd", m_req ? MEM_LOAD : MEM_NONE, m_req ? (m_pc & ~32'h7) : 32'h0,
                    m_req || m_tag != '0, vld, pk);
         if (rv) begin
            m_pc = rpc & ~32'h3; m_req = 1; m_tag = '0; m_full = 0;
         end else if (!m_req && m_tag == '0 && !m_full) begin
            m_req = 1;
         end else if (m_req && tt != '0) begin
            m_req = 0; m_tag = tt;
         end else if (m_tag != '0 && dt == m_tag) begin
            m_full = 1; m_blk = d; m_tag = '0;
         end else if (m_full && vld != 0) begin
            m_pc = (m_pc & ~32'h7) + 32'd8; m_full = 0; m_req = 1;
         end
      end
   endtask

   localparam MEM_BLOCK B0 = 64'hBBBB0002_AAAA0001;
   localparam MEM_BLOCK B1 = 64'h22220004_11110003;
   localparam MEM_BLOCK B2 = 64'hDDDD0006_CCCC0005;
   localparam MEM_BLOCK B3 = 64'h44440008_33330007;
   localparam MEM_BLOCK BS = 64'hDEADDEAD_BEEFBEEF;
   localparam MEM_BLOCK BG = 64'h66660010_5555000F;
   localparam MEM_BLOCK BR = 64'h88880012_77770011;

   initial begin
      // Reset held for two edges; outputs must be quiet throughout.
      hand("reset", 1, 0, 0, 0, 0, 0, 3'd4, MEM_NONE, 0, 0, 0, '0);

      tbl.push_back(mk(0, 0,      0, 0, 0,  4, MEM_NONE, 32'h0,   0, 0, '0));
      tbl.push_back(mk(0, 0,      0, 0, 0,  4, MEM_LOAD, 32'h0,   1, 0, '0));
      tbl.push_back(mk(0, 0,      3, 0, 0,  4, MEM_LOAD, 32'h0,   1, 0, '0));
      tbl.push_back(mk(0, 0,      0, 0, 0,  4, MEM_NONE, 32'h0,   1, 0, '0));
      tbl.push_back(mk(0, 0,      0, 3, B0, 4, MEM_NONE, 32'h0,   1, 0, '0));
      tbl.push_back(mk(0, 0,      0, 0, 0,  4, MEM_NONE, 32'h0,   0, 2,
                       {32'hBBBB0002, 32'h4, 32'hAAAA0001, 32'h0}));
      tbl.push_back(mk(0, 0,      0, 0, 0,  4, MEM_LOAD, 32'h8,   1, 0, '0));
      tbl.push_back(mk(0, 0,      7, 0, 0,  4, MEM_LOAD, 32'h8,   1, 0, '0));
      tbl.push_back(mk(0, 0,      0, 2, BS, 4, MEM_NONE, 32'h0,   1, 0, '0));
      tbl.push_back(mk(0, 0,      0, 7, B1, 4, MEM_NONE, 32'h0,   1, 0, '0));
      tbl.push_back(mk(0, 0,      0, 0, 0,  1, MEM_NONE, 32'h0,   0, 0, '0));
      tbl.push_back(mk(0, 0,      0, 0, 0,  1, MEM_NONE, 32'h0,   0, 0, '0));
      tbl.push_back(mk(0, 0,      0, 0, 0,  0, MEM_NONE, 32'h0,   0, 0, '0));
      tbl.push_back(mk(0, 0,      0, 0, 0,  2, MEM_NONE, 32'h0,   0, 2,
                       {32'h22220004, 32'hC, 32'h11110003, 32'h8}));
      tbl.push_back(mk(1, 32'h107, 0, 0, 0, 4, MEM_LOAD, 32'h10,  1, 0, '0));
      tbl.push_back(mk(0, 0,      9, 0, 0,  4, MEM_LOAD, 32'h100, 1, 0, '0));
      tbl.push_back(mk(0, 0,      0, 9, B2, 4, MEM_NONE, 32'h0,   1, 0, '0));
      tbl.push_back(mk(0, 0,      0, 0, 0,  1, MEM_NONE, 32'h0,   0, 1,
                       {64'h0, 32'hDDDD0006, 32'h104}));
      tbl.push_back(mk(0, 0,      0, 0, 0,  4, MEM_LOAD, 32'h108, 1, 0, '0));
      tbl.push_back(mk(0, 0,      4, 0, 0,  4, MEM_LOAD, 32'h108, 1, 0, '0));
      tbl.push_back(mk(0, 0,      0, 4, B3, 4, MEM_NONE, 32'h0,   1, 0, '0));
      tbl.push_back(mk(1, 32'h200, 0, 0, 0, 3, MEM_NONE, 32'h0,   0, 0, '0));
      tbl.push_back(mk(0, 0,      0, 0, 0,  4, MEM_LOAD, 32'h200, 1, 0, '0));

      foreach (tbl[k]) begin
         apply(0, tbl[k].rv, tbl[k].rpc, tbl[k].tt, tbl[k].dt, tbl[k].d, tbl[k].sp);
         expect_out($sformatf("vec%0d", k), tbl[k].cmd, tbl[k].addr, tbl[k].busy,
                    tbl[k].vld, tbl[k].pk);
      end

      // Squash in WAIT: the stale tag 5 response must be ignored.
      hand("sq_acc",   0, 0, 0,       5, 0, 0,  4, MEM_LOAD, 32'h200, 1, 0, '0);
      hand("sq_redir", 0, 1, 32'h200, 0, 0, 0,  4, MEM_NONE, 32'h0,   1, 0, '0);
      hand("sq_stale", 0, 0, 0,       0, 5, BS, 4, MEM_LOAD, 32'h200, 1, 0, '0);
      hand("sq_acc2",  0, 0, 0,       6, 0, 0,  4, MEM_LOAD, 32'h200, 1, 0, '0);
      hand("sq_stal2", 0, 0, 0,       0, 5, BS, 4, MEM_NONE, 32'h0,   1, 0, '0);
      hand("sq_data",  0, 0, 0,       0, 6, BG, 4, MEM_NONE, 32'h0,   1, 0, '0);
      hand("sq_deliv", 0, 0, 0,       0, 0, 0,  2, MEM_NONE, 32'h0,   0, 2,
           {32'h66660010, 32'h204, 32'h5555000F, 32'h200});

      // Redirect in REQ while a tag is accepted: tag 8 is discarded.
      hand("ra_redir", 0, 1, 32'h300, 8, 0, 0,  4, MEM_LOAD, 32'h208, 1, 0, '0);
      hand("ra_req",   0, 0, 0,       0, 8, BS, 4, MEM_LOAD, 32'h300, 1, 0, '0);
      hand("ra_acc",   0, 0, 0,       2, 0, 0,  4, MEM_LOAD, 32'h300, 1, 0, '0);
      hand("ra_stale", 0, 0, 0,       0, 8, BS, 4, MEM_NONE, 32'h0,   1, 0, '0);
      hand("ra_data",  0, 0, 0,       0, 2, BR, 4, MEM_NONE, 32'h0,   1, 0, '0);
      hand("ra_deliv", 0, 0, 0,       0, 0, 0,  4, MEM_NONE, 32'h0,   0, 2,
           {32'h88880012, 32'h304, 32'h77770011, 32'h300});

      // Reset mid-transaction drops the outstanding tag.
      hand("rm_acc",   0, 0, 0,       10, 0, 0,  4, MEM_LOAD, 32'h308, 1, 0, '0);
      hand("rm_reset", 1, 0, 0,       0, 10, BS, 4, MEM_NONE, 32'h0,   0, 0, '0);
      hand("rm_idle",  0, 0, 0,       0, 10, BS, 4, MEM_NONE, 32'h0,   0, 0, '0);
      hand("rm_req",   0, 0, 0,       0, 10, BS, 4, MEM_LOAD, 32'h0,   1, 0, '0);

      // Random traffic against the model.
      model_cycle(1, 0, 0, 0, 0, 0, 3'd0);
      for (int c = 0; c < 1500; c++) begin
         logic     rst, rv;
         MEM_TAG   tt, dt;
         int unsigned sel;
         rst = ($urandom_range(0, 99) == 0);
         rv  = ($urandom_range(0, 15) == 0);
         tt  = ($urandom_range(0, 2) == 0) ? MEM_TAG'($urandom) : '0;
         sel = $urandom_range(0, 3);
         dt  = (sel == 0) ? m_tag : (sel == 1) ? MEM_TAG'($urandom) : '0;
         model_cycle(rst, rv, $urandom, tt, dt, {$urandom, $urandom},
                     3'($urandom_range(0, 4)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_mem_ctrl.md
Name: fetch_mem_ctrl

Overview:
Sequences instruction-memory traffic for the fetch stage. It issues one block load at a time for the current fetch PC, matches the returned data by memory tag, and splits the 64-bit block into FETCH_PACKETs. Packets go to the instruction buffer only when enough spots are free. A mispredict redirect squashes any in-flight transaction and restarts at the redirect PC.

Parameters:
RESET_PC, 32'h0, fetch PC loaded on reset.
INSTS_PER_BLOCK, 2, instructions per MEM_BLOCK (64-bit block, 32-bit INST); fixed by memory width; requires `N >= 2.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  mispredict recovery this cycle
redirect_PC  in  ADDR  correct PC after mispredict; bits [1:0] ignored
Imem2proc_transaction_tag  in  MEM_TAG  nonzero = request accepted, with this tag
Imem2proc_data_tag  in  MEM_TAG  nonzero = data for this tag present on Imem2proc_data
Imem2proc_data  in  MEM_BLOCK  returned instruction block
Imem_command  out  MEM_COMMAND  MEM_LOAD or MEM_NONE
Imem_addr  out  ADDR  8-byte-aligned block address
inst_buffer_spots  in  [`NUM_SCALAR_BITS-1:0]  free instruction-buffer entries
inst_buffer_inputs  out  FETCH_PACKET [`N-1:0]  packets, oldest in index 0
instructions_valid  out  [`NUM_SCALAR_BITS-1:0]  number of valid packets this cycle
fetch_busy  out  1  high in REQ or WAIT

Behaviour:
- State: fetch_PC (ADDR), saved_tag (MEM_TAG), block_reg (MEM_BLOCK), FSM {IDLE, REQ, WAIT, DELIVER}.
- Reset: fetch_PC=RESET_PC, saved_tag=0, state=IDLE. Outputs are Imem_command=MEM_NONE, Imem_addr=0, instructions_valid=0, inst_buffer_inputs='0, fetch_busy=0. A reset in any state, including mid-transaction, discards the outstanding tag.
- IDLE: unconditionally go to REQ the next cycle.
- REQ: Imem_command=MEM_LOAD, Imem_addr={fetch_PC[31:3],3'b000}. Request is held every cycle until Imem2proc_transaction_tag!=0. On acceptance, saved_tag<=transaction_tag and go to WAIT.
- WAIT: Imem_command=MEM_NONE. When Imem2proc_data_tag==saved_tag and data_tag!=0, block_reg<=Imem2proc_data and go to DELIVER. A data_tag of 0 never matches. Non-matching tags are ignored.
- DELIVER: cnt = fetch_PC[2] ? 1 : 2. First instruction is block_reg word fetch_PC[2].
  - If inst_buffer_spots >= cnt: instructions_valid=cnt. Packet i gets .inst = word (fetch_PC[2]+i) and .PC = fetch_PC+4*i. Unused packets are '0. Then fetch_PC<={fetch_PC[31:3]+1,3'b000} and go to REQ.
  - Else instructions_valid=0 and hold. Delivery is all-or-nothing, never partial.
- Outputs to the buffer are combinational from registered state (block_reg, fetch_PC, state).
- Redirect has highest priority and applies in any state:
  - fetch_PC<={redirect_PC[31:2],2'b00}, saved_tag<=0, next state=REQ.
  - In that cycle instructions_valid is forced to 0.
  - A transaction tag accepted in the same cycle is discarded, and a later response for it never matches.
  - Imem_command still reflects the current state that cycle.
- Latency: tag accepted in cycle t, data in cycle t+k, packets valid in cycle t+k+1 at the earliest. The next request issues in cycle t+k+2.
- fetch_PC wraps modulo 2^32.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles[31:0] (cycles in DELIVER with insufficient spots) and perf_squashed_reqs[31:0] (redirects taken while in WAIT, or in REQ with acceptance that cycle). Both reset to 0, saturate at all-ones, and have no effect on other behaviour.
- Undefined: ports and counters absent.

Decomposition:
- Shared package: FETCH_PACKET {INST inst; ADDR PC}, MEM_COMMAND, MEM_TAG, MEM_BLOCK, fetch FSM state enum, INSTS_PER_BLOCK constant.
- One natural sub-module, fetch_block_split: combinational block-to-packets extraction given offset and cnt. The FSM and registers stay in the top.

Test Plan:
- Reset: RESET_PC=0, then hold reset 1 cycle -> next cycle REQ with Imem_addr=0x0, command=MEM_LOAD; outputs zero during reset.
- Normal fetch: transaction_tag=3 in REQ, data_tag=3 two cycles later with block {0xBBBB0002,0xAAAA0001}, spots=4 -> next cycle instructions_valid=2, packet0 {0xAAAA0001, PC 0x0}, packet1 {0xBBBB0002, PC 0x4}; next Imem_addr=0x8.
- Unaligned start: redirect_PC=0x104, block returned -> instructions_valid=1, packet0 carries upper word with PC 0x104; next Imem_addr=0x108.
- Backpressure: spots=1 with cnt=2 for 3 cycles -> instructions_valid=0 and state held. Spots=2 -> delivered once.
- Squash: redirect_PC=0x200 in WAIT on tag 5, stale data_tag=5 returns -> ignored; REQ at 0x200; only the new tag's data delivered.
- Redirect in DELIVER with spots sufficient -> instructions_valid=0 that cycle; next REQ address 0x200.
